// File: rtl/eeprom_key_reader.sv
// I2C random-read master: fetches one byte from a 24xx serial EEPROM per request.
// Open-drain bus outputs are registered and derived from the next slot position.
module eeprom_key_reader #(
  parameter int unsigned CLK_DIV  = 16,
  parameter logic [6:0]  DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_load_req,
  input  logic [6:0] key_addr,
  output logic [7:0] key_data,
  output logic       key_data_valid,
  output logic       nack_err,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i
);

  localparam int unsigned    DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    StIdle, StStart, StWrDev, StWrAddr, StRstart, StRdDev, StRdData, StMnack, StStop, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      phase_q, phase_d;
  logic [2:0]      bit_q, bit_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [6:0]      addr_q, addr_d;
  logic [7:0]      shift_q, shift_d;

  logic [7:0] key_data_d;
  logic       valid_d, nack_d, busy_d, scl_oe_d, sda_oe_d;
  logic [7:0] tx_byte;
  logic       slot_end, sample, entering_done;

  assign slot_end = (phase_q == 2'd3) && (div_q == DivLast);
  // sda_i is sampled on the last cycle of P1, while SCL is high.
  assign sample   = (phase_q == 2'd1) && (div_q == DivLast);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    ack_d   = ack_q;
    err_d   = err_q;
    addr_d  = addr_q;
    shift_d = shift_q;

    if (state_q != StIdle && state_q != StDone) begin
      if (div_q == DivLast) begin
        div_d   = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        div_d = div_q + DivW'(1);
      end
    end

    if (sample) begin
      if (state_q == StRdData) begin
        shift_d = {shift_q[6:0], sda_i};
      end else if (ack_q) begin
        err_d = sda_i;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (key_load_req) begin
          state_d = StStart;
          addr_d  = key_addr;
          err_d   = 1'b0;
          div_d   = '0;
          phase_d = 2'd0;
          bit_d   = 3'd7;
          ack_d   = 1'b0;
        end
      end
      StStart: begin
        if (slot_end) begin
          state_d = StWrDev;
          bit_d   = 3'd7;
          ack_d   = 1'b0;
        end
      end
      StWrDev, StWrAddr, StRdDev: begin
        if (slot_end) begin
          if (!ack_q) begin
            if (bit_q == 3'd0) begin
              ack_d = 1'b1;
            end else begin
              bit_d = bit_q - 3'd1;
            end
          end else begin
            ack_d = 1'b0;
            bit_d = 3'd7;
            if (err_q) begin
              state_d = StStop;
            end else if (state_q == StWrDev) begin
              state_d = StWrAddr;
            end else if (state_q == StWrAddr) begin
              state_d = StRstart;
            end else begin
              state_d = StRdData;
            end
          end
        end
      end
      StRstart: begin
        if (slot_end) begin
          state_d = StRdDev;
          bit_d   = 3'd7;
          ack_d   = 1'b0;
        end
      end
      StRdData: begin
        if (slot_end) begin
          if (bit_q == 3'd0) begin
            state_d = StMnack;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end
      end
      StMnack: begin
        if (slot_end) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (slot_end) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus levels are computed for the position being entered so the registered pins line up with it.
  always_comb begin
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    tx_byte  = {DEV_ADDR, 1'b1};
    case (state_d)
      StWrDev:  tx_byte = {DEV_ADDR, 1'b0};
      StWrAddr: tx_byte = {1'b0, addr_d};
      default:  tx_byte = {DEV_ADDR, 1'b1};
    endcase
    case (state_d)
      StStart, StRstart: begin
        scl_oe_d = (phase_d == 2'd0) || (phase_d == 2'd3);
        sda_oe_d = (phase_d == 2'd2) || (phase_d == 2'd3);
      end
      StWrDev, StWrAddr, StRdDev: begin
        scl_oe_d = (phase_d == 2'd0) || (phase_d == 2'd3);
        sda_oe_d = !ack_d && !tx_byte[bit_d];
      end
      StRdData, StMnack: begin
        scl_oe_d = (phase_d == 2'd0) || (phase_d == 2'd3);
      end
      StStop: begin
        scl_oe_d = (phase_d == 2'd0);
        sda_oe_d = (phase_d == 2'd0) || (phase_d == 2'd1);
      end
      default: ;
    endcase
  end

  assign entering_done = (state_q == StStop) && (state_d == StDone);

  always_comb begin
    valid_d    = entering_done && !err_q;
    nack_d     = entering_done && err_q;
    key_data_d = valid_d ? shift_q : key_data;
    busy_d     = (state_d != StIdle) && (state_d != StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      div_q          <= '0;
      phase_q        <= 2'd0;
      bit_q          <= 3'd7;
      ack_q          <= 1'b0;
      err_q          <= 1'b0;
      addr_q         <= 7'd0;
      shift_q        <= 8'd0;
      key_data       <= 8'd0;
      key_data_valid <= 1'b0;
      nack_err       <= 1'b0;
      busy           <= 1'b0;
      scl_oe         <= 1'b0;
      sda_oe         <= 1'b0;
    end else begin
      state_q        <= state_d;
      div_q          <= div_d;
      phase_q        <= phase_d;
      bit_q          <= bit_d;
      ack_q          <= ack_d;
      err_q          <= err_d;
      addr_q         <= addr_d;
      shift_q        <= shift_d;
      key_data       <= key_data_d;
      key_data_valid <= valid_d;
      nack_err       <= nack_d;
      busy           <= busy_d;
      scl_oe         <= scl_oe_d;
      sda_oe         <= sda_oe_d;
    end
  end

endmodule
